// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types for the single-port SRAM access controller: controller state
// and the write-buffer entry layout of the 512x59 instance.
package ct_spsram_ctrl_pkg;

    localparam int SRAM_AW = 9;
    localparam int SRAM_DW = 59;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] data;
        logic [SRAM_DW-1:0] mask;
    } wbuf_entry_t;

endpackage

// File: rtl/ct_spsram_wbuf.sv
// In-order write buffer: circular FIFO with occupancy counter and a parallel
// address comparator over the valid entries, used for read-hazard detection.
module ct_spsram_wbuf
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter int  AW      = SRAM_AW,
    parameter type entry_t = wbuf_entry_t
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    output entry_t        head_entry,
    input  logic [AW-1:0] match_addr,
    output logic          hit,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t            entries_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [CW-1:0]     count_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign head_entry = entries_r[head_r];
    assign full       = (count_r == CW'(DEPTH));
    assign empty      = (count_r == {CW{1'b0}});

    // Storage, per-entry valid flags, pointers and occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
            valid_r <= {DEPTH{1'b0}};
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push) begin
                entries_r[tail_r] <= push_entry;
                valid_r[tail_r]   <= 1'b1;
                tail_r            <= ptr_inc(tail_r);
            end
            if (pop) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= ptr_inc(head_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Any valid entry targeting the probed address is a hazard.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit = hit | (valid_r[i] & (entries_r[i].addr == match_addr));
        end
    end

endmodule

// File: rtl/ct_f_spsram_512x59_ctrl.sv
// Access controller in front of the 512x59 single-port SRAM: post-reset zero
// sweep, buffered writes, hazard-checked reads, one SRAM operation per cycle.
module ct_f_spsram_512x59_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_AW,
    parameter int DATA_WIDTH = SRAM_DW,
    parameter int WBUF_DEPTH = 2,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  wr_vld,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_ready,
    output logic                  init_done,
    output logic                  wbuf_empty,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] mask;
    } entry_t;

    localparam ctrl_state_e           RESET_STATE = (INIT_EN != 0) ? INIT : RUN;
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST   = {ADDR_WIDTH{1'b1}};

    ctrl_state_e           state_r;
    ctrl_state_e           state_nxt_s;
    logic [ADDR_WIDTH-1:0] init_cnt_r;
    logic [ADDR_WIDTH-1:0] init_cnt_nxt_s;
    logic                  rsp_vld_r;

    logic                  run_s;
    logic                  init_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  rd_issue_s;
    logic                  hit_s;
    logic                  full_s;
    logic                  empty_s;
    entry_t                push_entry_s;
    entry_t                head_s;

    // While RST is held nothing is driven to the macro and no request is taken.
    assign run_s  = (state_r == RUN)  && !RST;
    assign init_s = (state_r == INIT) && !RST;

    assign wr_ready     = run_s && !full_s;
    assign push_s       = wr_vld && wr_ready && (wr_mask != {DATA_WIDTH{1'b0}});
    assign push_entry_s = '{addr: wr_addr, data: wr_data, mask: wr_mask};

    ct_spsram_wbuf #(
        .DEPTH   (WBUF_DEPTH),
        .AW      (ADDR_WIDTH),
        .entry_t (entry_t)
    ) u_wbuf (
        .CLK        (CLK),
        .RST        (RST),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head_entry (head_s),
        .match_addr (rd_addr),
        .hit        (hit_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    // State register and sweep counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= RESET_STATE;
            init_cnt_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            init_cnt_r <= init_cnt_nxt_s;
        end
    end

    // Next state: sweep every address once, then stay in RUN.
    always_comb begin
        state_nxt_s    = state_r;
        init_cnt_nxt_s = init_cnt_r;
        case (state_r)
            INIT: begin
                init_cnt_nxt_s = init_cnt_r + ADDR_WIDTH'(1);
                if (init_cnt_r == INIT_LAST) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            RUN: begin
                state_nxt_s    = RUN;
                init_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
            end
            default: begin
                state_nxt_s    = RESET_STATE;
                init_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Arbiter: a full buffer drains first so writers always make progress.
    always_comb begin
        pop_s      = 1'b0;
        rd_issue_s = 1'b0;
        if (run_s) begin
            if (full_s) begin
                pop_s = 1'b1;
            end else if (rd_vld && !hit_s) begin
                rd_issue_s = 1'b1;
            end else if (!empty_s) begin
                pop_s = 1'b1;
            end else begin
                pop_s      = 1'b0;
                rd_issue_s = 1'b0;
            end
        end else begin
            pop_s      = 1'b0;
            rd_issue_s = 1'b0;
        end
    end

    // SRAM pin drive for the single operation selected this cycle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = {DATA_WIDTH{1'b1}};
        sram_a    = {ADDR_WIDTH{1'b0}};
        sram_d    = {DATA_WIDTH{1'b0}};
        if (init_s) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = {DATA_WIDTH{1'b0}};
            sram_a    = init_cnt_r;
        end else if (pop_s) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~head_s.mask;
            sram_a    = head_s.addr;
            sram_d    = head_s.data;
        end else if (rd_issue_s) begin
            sram_cen  = 1'b0;
            sram_a    = rd_addr;
        end else begin
            sram_cen  = 1'b1;
            sram_gwen = 1'b1;
        end
    end

    // Response valid follows an issued read by exactly one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_vld_r <= 1'b0;
        end else begin
            rsp_vld_r <= rd_issue_s;
        end
    end

    assign rd_ready   = rd_issue_s;
    assign rsp_vld    = rsp_vld_r;
    assign rsp_data   = rsp_vld_r ? sram_q : {DATA_WIDTH{1'b0}};
    assign init_done  = run_s;
    assign wbuf_empty = empty_s;

endmodule

// File: doc/ct_f_spsram_512x59_ctrl.md
# ct_f_spsram_512x59_ctrl

Access controller sitting directly upstream of the 512x59 single-port SRAM macro. It sequences one SRAM operation per cycle from separate read and write request streams. Writes are absorbed into a small in-order write buffer, and reads are stalled only on an address hazard. After reset it zero-initialises the array and then returns read data one cycle after a read is issued.

## Interface
Parameters:
- ADDR_WIDTH, 9, SRAM address width; array depth is 2^ADDR_WIDTH
- DATA_WIDTH, 59, SRAM word width
- WBUF_DEPTH, 2, write-buffer entries (≥1)
- INIT_EN, 1, 1 = sweep-zero the array after reset; 0 = skip straight to RUN

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- rd_vld  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_ready  out  1  read accepted this cycle
- rsp_vld  out  1  read data valid (no backpressure)
- rsp_data  out  DATA_WIDTH  read data
- wr_vld  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  DATA_WIDTH  active-high bit enables
- wr_ready  out  1  write accepted this cycle
- init_done  out  1  array initialised, controller in RUN
- wbuf_empty  out  1  no pending writes
- sram_a  out  ADDR_WIDTH  SRAM address
- sram_cen  out  1  SRAM chip enable, active-low
- sram_gwen  out  1  SRAM global write enable, active-low
- sram_wen  out  DATA_WIDTH  SRAM bit write enables, active-low
- sram_d  out  DATA_WIDTH  SRAM write data
- sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access

## Operation
- States: INIT, RUN.
  - Reset enters INIT if INIT_EN=1, otherwise RUN.
  - INIT issues a full-width zero write to init_cnt = 0 … 2^ADDR_WIDTH−1, one address per cycle, then moves to RUN.
  - rd_ready = wr_ready = 0 throughout INIT.
- Write buffer: FIFO of {addr, data, mask}.
  - wr_ready = RUN && !full. There is no same-cycle pass-through when full.
  - A write with wr_mask == 0 is accepted but never enqueued.
- Arbitration (RUN), evaluated each cycle in priority order; at most one SRAM op per cycle:
  1. Buffer full → drain the head entry.
  2. Otherwise, rd_vld and rd_addr matches no valid buffer entry → issue the read.
  3. Otherwise, buffer non-empty → drain the head entry.
  4. Otherwise → idle (sram_cen=1).
- rd_ready is 1 exactly when the read is issued.
- Ordering:
  - A read whose address matches a buffered entry stalls until every matching entry has drained.
  - A read issued in the same cycle a write to the same address is accepted is older and returns pre-write data.
- Drain drive: sram_cen=0, sram_gwen=0, sram_wen=~mask, sram_a=addr, sram_d=data.
- Read drive: sram_cen=0, sram_gwen=1, sram_wen all 1s, sram_a=rd_addr.
- Idle drive: sram_cen=1, sram_gwen=1, sram_wen all 1s, sram_a=0, sram_d=0.
- SRAM drive outputs are combinational from registered state and current requests.
- Response path: rsp_vld is a register set by an issued read. rsp_data = sram_q while rsp_vld=1, otherwise 0.

## Timing
- Reset values, and values held while RST=1:
  - rd_ready=0, wr_ready=0, rsp_vld=0, rsp_data=0, init_done=0, wbuf_empty=1
  - sram_cen=1, sram_gwen=1, sram_wen all 1s
- INIT: the first zero write occurs in the first cycle after RST deasserts. init_done rises the cycle after the last sweep write, i.e. 2^ADDR_WIDTH cycles after deassert.
- Read issued at edge N → rsp_vld=1 with data in cycle N+1. Back-to-back reads give one response per cycle.
- A write accepted at edge N is visible in the buffer from cycle N+1 and can drain at the earliest in N+1.
- RST mid-operation: the buffer is cleared and pending writes are lost. An in-flight response is dropped. The controller re-enters INIT.
- Progress guarantee: a full buffer always drains. A read stalls at most WBUF_DEPTH drain cycles after its hazard begins.

## Structure
- Package ct_spsram_ctrl_pkg holds:
  - state enum {INIT, RUN}
  - wbuf entry struct {addr, data, mask}, parameterised through package localparams for the 512x59 instance
- Sub-module ct_spsram_wbuf: FIFO with head/tail pointers, an occupancy counter, and a parallel address-match output (hit) over valid entries.
- The top level holds the state machine, init counter, arbiter and response register.

## Test plan
- Init sweep: deassert RST → sram_cen=0 and sram_gwen=0 with sram_a = 0, 1, …, 511 on consecutive cycles; init_done=1 after 512 cycles; then read addr 5 → rsp_data=0 one cycle later.
- Hazard: write addr 0x10 data 0x123 full mask, then read 0x10 in the next cycle → write drains first, read issues a cycle later, rsp_data=0x123.
- Partial mask: write 0x20 with all-ones data (after init), then write 0x20 data 0 mask bit 0 only → read returns all-ones except bit 0 = 0.
- Full buffer: with WBUF_DEPTH=2, fill the buffer while a continuous read stream to other addresses runs → wr_ready=0 while full, head drains ahead of the read, reads resume the next cycle.
- Same-cycle ordering: read and write to 0x30 accepted in the same cycle → read returns the old value; a later read returns the new value.
- Reset mid-operation: assert RST with 2 buffered writes and an in-flight read → rsp_vld=0 and wbuf_empty=1 immediately; INIT restarts at addr 0; the discarded writes never reach the SRAM.
